uart_apb_master: RTL and testbench

- Debug-bridge APB initiator. Consumes a framed command byte stream from the UART receiver and issues single APB read/write transfers to the debug register slave.
- Returns result bytes to the UART transmitter.
- Sits between the UART byte engines and the debug APB bus. It is the only APB requester on that bus.

---
 rtl/uart_apb_master_pkg.sv | 18 +
 rtl/uart_apb_master.sv | 168 ++++++++++++++++
 tb/tb_uart_apb_master.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_master_pkg.sv
// Shared command/response codes and FSM state encoding for the UART-to-APB debug bridge.
package uart_apb_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WDATA  = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_ACCESS = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

endpackage

// File: rtl/uart_apb_master.sv
// UART byte-stream to APB single-transfer initiator with serialized byte responses.
// Optional ACCESS-phase timeout is enabled by defining UART_APBM_TIMEOUT_EN.
module uart_apb_master
  import uart_apb_master_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_apb,
  input  logic              rst_apb_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              apb_uart_psel,
  output logic              apb_uart_penable,
  output logic              apb_uart_pwrite,
  output logic [ADDR_W-1:0] apb_uart_paddr,
  output logic [31:0]       apb_uart_pwdata,
  input  logic [31:0]       uart_apb_prdata,
  input  logic              uart_apb_pready,
  input  logic              uart_apb_pslverr
);

  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [7:0]  addr_lo;
  logic [31:0] resp_sr;
  logic [2:0]  resp_cnt;
  logic        rx_fire;
  logic        tx_fire;
  logic        tmo_hit;
  logic [31:0] rsp_word;
  logic [7:0]  rsp_status;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

`ifdef UART_APBM_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_cnt;

  // Counts ACCESS cycles; the TIMEOUT_CYCLES-th cycle without pready ends the transfer.
  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n)              tmo_cnt <= '0;
    else if (state == ST_ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
    else                         tmo_cnt <= '0;
  end

  assign tmo_hit = (state == ST_ACCESS) && !uart_apb_pready &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    rsp_word   = uart_apb_prdata;
    rsp_status = uart_apb_pslverr ? RSP_ERR : RSP_OK;
    if (tmo_hit) begin
      rsp_word   = 32'h0;
      rsp_status = RSP_TMO;
    end
  end

  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      state            <= ST_IDLE;
      byte_cnt         <= 2'd0;
      addr_lo          <= 8'h00;
      resp_sr          <= 32'h0;
      resp_cnt         <= 3'd0;
      rx_ready         <= 1'b0;
      tx_valid         <= 1'b0;
      tx_data          <= 8'h00;
      apb_uart_psel    <= 1'b0;
      apb_uart_penable <= 1'b0;
      apb_uart_pwrite  <= 1'b0;
      apb_uart_paddr   <= '0;
      apb_uart_pwdata  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              apb_uart_pwrite <= (rx_data == CMD_WR);
              byte_cnt        <= 2'd0;
              state           <= ST_ADDR;
            end else begin
              rx_ready <= 1'b0;
              tx_data  <= RSP_BAD;
              tx_valid <= 1'b1;
              resp_cnt <= 3'd0;
              state    <= ST_RESP;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire) begin
            if (byte_cnt == 2'd0) begin
              addr_lo  <= rx_data;
              byte_cnt <= 2'd1;
            end else begin
              apb_uart_paddr <= ADDR_W'({rx_data, addr_lo});
              byte_cnt       <= 2'd0;
              if (apb_uart_pwrite) begin
                state <= ST_WDATA;
              end else begin
                rx_ready      <= 1'b0;
                apb_uart_psel <= 1'b1;
                state         <= ST_SETUP;
              end
            end
          end
        end
        ST_WDATA: begin
          if (rx_fire) begin
            apb_uart_pwdata[8*byte_cnt +: 8] <= rx_data;
            byte_cnt                         <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              rx_ready      <= 1'b0;
              apb_uart_psel <= 1'b1;
              state         <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          apb_uart_penable <= 1'b1;
          state            <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Response byte 0 is loaded here so tx_valid rises right as psel drops.
          if (uart_apb_pready || tmo_hit) begin
            apb_uart_psel    <= 1'b0;
            apb_uart_penable <= 1'b0;
            tx_valid         <= 1'b1;
            state            <= ST_RESP;
            if (apb_uart_pwrite) begin
              tx_data  <= rsp_status;
              resp_cnt <= 3'd0;
            end else begin
              tx_data  <= rsp_word[7:0];
              resp_sr  <= {rsp_status, rsp_word[31:8]};
              resp_cnt <= 3'd4;
            end
          end
        end
        ST_RESP: begin
          if (tx_fire) begin
            if (resp_cnt == 3'd0) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              tx_data  <= resp_sr[7:0];
              resp_sr  <= {8'h00, resp_sr[31:8]};
              resp_cnt <= resp_cnt - 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: frame-level model, APB slave model, per-cycle compare.
module tb_uart_apb_master;

  localparam int TMO = 16;

  logic        clk_apb;
  logic        rst_apb_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        apb_uart_psel;
  logic        apb_uart_penable;
  logic        apb_uart_pwrite;
  logic [11:0] apb_uart_paddr;
  logic [31:0] apb_uart_pwdata;
  logic [31:0] uart_apb_prdata;
  logic        uart_apb_pready;
  logic        uart_apb_pslverr;

  uart_apb_master #(.ADDR_W(12), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_apb          (clk_apb),
    .rst_apb_n        (rst_apb_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .apb_uart_psel    (apb_uart_psel),
    .apb_uart_penable (apb_uart_penable),
    .apb_uart_pwrite  (apb_uart_pwrite),
    .apb_uart_paddr   (apb_uart_paddr),
    .apb_uart_pwdata  (apb_uart_pwdata),
    .uart_apb_prdata  (uart_apb_prdata),
    .uart_apb_pready  (uart_apb_pready),
    .uart_apb_pslverr (uart_apb_pslverr)
  );

  initial begin
    clk_apb = 1'b0;
    forever #5 clk_apb = ~clk_apb;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_apb) cyc <= cyc + 1;

  // APB slave: pready rises after wait_cfg ACCESS cycles.
  int          wait_cfg  = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic        err_cfg   = 1'b0;
  int          acc_cnt   = 0;

  always @(posedge clk_apb) begin
    if (apb_uart_penable && !uart_apb_pready) acc_cnt <= acc_cnt + 1;
    else                                      acc_cnt <= 0;
  end
  assign uart_apb_pready  = apb_uart_penable && (acc_cnt == wait_cfg);
  assign uart_apb_prdata  = rdata_cfg;
  assign uart_apb_pslverr = err_cfg;

  typedef struct packed {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wd;
  } apb_t;

  logic [7:0] exp_tx[$];
  apb_t       exp_apb[$];
  logic [7:0] rx_log[$];
  bit         tmo_mode = 1'b0;

  int last_acc, psel_cyc, pen_cyc, first_txv, acc_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: expected bus transfer and response bytes.
  task automatic expect_rw(input bit wr, input logic [15:0] addr, input logic [31:0] wd);
    apb_t        e;
    logic [31:0] d;
    logic [7:0]  st;
    e.addr = addr[11:0];
    e.wr   = wr;
    e.wd   = wd;
    exp_apb.push_back(e);
    st = tmo_mode ? 8'h54 : (err_cfg ? 8'h45 : 8'h4B);
    d  = tmo_mode ? 32'h0 : rdata_cfg;
    if (!wr)
      for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    exp_tx.push_back(st);
  endtask

  // Compare process.
  logic       p_txv = 0, p_txr = 0, p_psel = 0, p_pen = 0, p_pwr = 0;
  logic [7:0] p_txd = 0;
  logic [11:0] p_addr = 0;
  logic [31:0] p_wd = 0;

  always @(negedge clk_apb) begin
    if (rst_apb_n) begin
      if (p_txv && !p_txr) begin
        chk("tx_hold_valid", tx_valid, 1'b1);
        chk("tx_hold_data", tx_data, p_txd);
      end
      if (tx_valid && !p_txv && first_txv < 0) first_txv = cyc;
      if (tx_valid && tx_ready) begin
        rx_log.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (apb_uart_psel && !apb_uart_penable) begin
        chk("setup_single", p_psel, 1'b0);
        if (!p_psel) begin
          psel_cyc = cyc;
          acc_len  = 0;
          if (exp_apb.size() == 0) begin
            checks++; errors++;
            $display("FAIL apb_unexpected: got addr %0h expected no transfer", apb_uart_paddr);
          end else begin
            apb_t e;
            e = exp_apb.pop_front();
            chk("paddr", apb_uart_paddr, e.addr);
            chk("pwrite", apb_uart_pwrite, e.wr);
            if (e.wr) chk("pwdata", apb_uart_pwdata, e.wd);
          end
        end
      end
      if (apb_uart_penable) begin
        acc_len++;
        chk("penable_psel", apb_uart_psel, 1'b1);
        if (!p_pen) begin
          pen_cyc = cyc;
          chk("setup_before_access", p_psel && !p_pen, 1'b1);
        end else begin
          chk("paddr_stable", apb_uart_paddr, p_addr);
          chk("pwrite_stable", apb_uart_pwrite, p_pwr);
          chk("pwdata_stable", apb_uart_pwdata, p_wd);
        end
      end
      if (apb_uart_psel || tx_valid) chk("rx_ready_busy", rx_ready, 1'b0);
    end
    p_txv  = tx_valid;
    p_txr  = tx_ready;
    p_txd  = tx_data;
    p_psel = apb_uart_psel;
    p_pen  = apb_uart_penable;
    p_addr = apb_uart_paddr;
    p_pwr  = apb_uart_pwrite;
    p_wd   = apb_uart_pwdata;
  end

  task automatic start_test();
    rx_log.delete();
    first_txv = -1;
    psel_cyc  = -1;
    pen_cyc   = -1;
    acc_len   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk_apb);
      t++;
    end while (!rx_ready && t < 500);
    chk("rx_accept_in_time", t < 500, 1'b1);
    last_acc = cyc;
    @(posedge clk_apb);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] wd);
    expect_rw(1'b1, addr, wd);
    send_byte(8'h57);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
  endtask

  task automatic do_read(input logic [15:0] addr);
    expect_rw(1'b0, addr, 32'h0);
    send_byte(8'h52);
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_apb.size() != 0 || tx_valid) && t < 3000) begin
      @(negedge clk_apb);
      t++;
    end
    chk("done_in_time", t < 3000, 1'b1);
    @(posedge clk_apb);
    #1;
  endtask

  task automatic check_log(input string name, input int n, input logic [39:0] lit);
    chk({name, "_len"}, rx_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rx_log.size()) chk(name, rx_log[i], lit[8*i +: 8]);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_rx_ready"}, rx_ready, 1'b0);
    chk({name, "_tx_valid"}, tx_valid, 1'b0);
    chk({name, "_tx_data"}, tx_data, 8'h00);
    chk({name, "_psel"}, apb_uart_psel, 1'b0);
    chk({name, "_penable"}, apb_uart_penable, 1'b0);
    chk({name, "_pwrite"}, apb_uart_pwrite, 1'b0);
    chk({name, "_paddr"}, apb_uart_paddr, 12'h000);
    chk({name, "_pwdata"}, apb_uart_pwdata, 32'h0);
  endtask

  initial begin
    rst_apb_n = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_ready  = 1'b1;
    start_test();
    repeat (3) @(posedge clk_apb);
    @(negedge clk_apb);
    check_reset("reset");
    @(posedge clk_apb);
    #1;
    rst_apb_n = 1'b1;

    // Zero-wait write, with latency checks.
    start_test();
    wait_cfg = 0; err_cfg = 1'b0;
    do_write(16'h0008, 32'h0000_0001);
    wait_done();
    check_log("wr_resp", 1, 40'h4B);
    chk("psel_N+1", psel_cyc - last_acc, 1);
    chk("penable_N+2", pen_cyc - last_acc, 2);
    chk("txvalid_N+3", first_txv - last_acc, 3);
    chk("wr_access_len", acc_len, 1);

    // Read with 3 wait states.
    start_test();
    wait_cfg = 3; rdata_cfg = 32'hDEAD_BEEF; err_cfg = 1'b0;
    do_read(16'h0004);
    wait_done();
    check_log("rd_resp", 5, 40'h4B_DEADBEEF);
    chk("rd_access_len", acc_len, 4);

    // Read with slave error.
    start_test();
    wait_cfg = 0; rdata_cfg = 32'h1234_5678; err_cfg = 1'b1;
    do_read(16'h0010);
    wait_done();
    check_log("err_resp", 5, 40'h45_12345678);

    // Bad command, then a read with ignored upper address bits.
    start_test();
    err_cfg = 1'b0; rdata_cfg = 32'h0BAD_F00D;
    exp_tx.push_back(8'h3F);
    send_byte(8'h41);
    wait_done();
    check_log("bad_resp", 1, 40'h3F);
    chk("bad_no_psel", psel_cyc, -1);
    start_test();
    do_read(16'hF123);
    wait_done();
    check_log("after_bad", 5, 40'h4B_0BADF00D);

    // Transmitter backpressure during a read response.
    start_test();
    rdata_cfg = 32'hCAFE_F00D;
    tx_ready  = 1'b0;
    do_read(16'h0020);
    begin
      int t;
      t = 0;
      while (!tx_valid && t < 200) begin
        @(negedge clk_apb);
        t++;
      end
      chk("bp_tx_seen", t < 200, 1'b1);
    end
    repeat (10) @(negedge clk_apb);
    chk("bp_data", tx_data, 8'h0D);
    chk("bp_valid", tx_valid, 1'b1);
    @(posedge clk_apb);
    #1;
    tx_ready = 1'b1;
    wait_done();
    check_log("bp_resp", 5, 40'h4B_CAFEF00D);

    // Reset in the middle of the write-data bytes.
    start_test();
    send_byte(8'h57);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_apb_n = 1'b0;
    @(posedge clk_apb);
    @(negedge clk_apb);
    check_reset("mid_reset");
    @(posedge clk_apb);
    #1;
    rst_apb_n = 1'b1;
    repeat (5) @(posedge clk_apb);
    #1;
    chk("mid_reset_no_tx", rx_log.size(), 0);
    start_test();
    do_write(16'h0123, 32'hA5A5_0F0F);
    wait_done();
    check_log("post_reset", 1, 40'h4B);

`ifdef UART_APBM_TIMEOUT_EN
    // Slave never responds: transfer ends after TMO ACCESS cycles.
    start_test();
    tmo_mode = 1'b1;
    wait_cfg = 1000000;
    do_read(16'h0030);
    wait_done();
    check_log("tmo_resp", 5, 40'h54_00000000);
    chk("tmo_access_len", acc_len, TMO);
    tmo_mode = 1'b0;
    wait_cfg = 0;
`endif

    repeat (3) @(posedge clk_apb);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
